// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and its iterative MUL/DIV unit.
package alu_pkg;

    // alu_op encodings from the main control unit
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ILL   = 2'b11;

    // R-type function field values
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_SLT,
        OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
    } op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    // Map alu_op/funct onto a single operation; anything unknown is OP_ILL
    function automatic op_e decode(input logic [1:0] alu_op, input logic [5:0] funct);
        op_e op;
        op = OP_ILL;
        case (alu_op)
            AOP_ADD: op = OP_ADD;
            AOP_SUB: op = OP_SUB;
            AOP_RTYPE: begin
                case (funct)
                    FN_ADDU:  op = OP_ADD;
                    FN_SUBU:  op = OP_SUB;
                    FN_SLL:   op = OP_SLL;
                    FN_SRL:   op = OP_SRL;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_SLT:   op = OP_SLT;
                    FN_MULTU: op = OP_MULTU;
                    FN_DIVU:  op = OP_DIVU;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
                    default:  op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Shared one-bit-per-cycle MUL/DIV datapath: a 2*WIDTH shift register
// {upper, lower} plus iteration counter. done is high in the cycle whose
// closing edge performs the last iteration; hi_nxt/lo_nxt are that result.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, div_q, div_d;
    logic [WIDTH:0]     sum, rem_sh, diff;

    // One iteration. MUL: lower half is the multiplier, add b into the upper
    // half when its LSB is set, then shift right. DIV: lower half holds the
    // dividend shifting out into the remainder and quotient bits shifting in.
    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (div_q) begin
            if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0]) acc_step = {sum, acc_q[WIDTH-1:1]};
            else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign hi_nxt = acc_step[2*WIDTH-1:WIDTH];
    assign lo_nxt = acc_step[WIDTH-1:0];

    // Load on start, iterate while busy; counter ends at WIDTH
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            b_d    = b;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = op_div;
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder + single-cycle ALU with a registered valid/ready result,
// HI/LO registers and an iterative multu/divu unit that holds off new requests.
// WIDTH must be a power of two, at least 4.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic             accept, mdu_start, mdu_div, mdu_done;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    op_e              op;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign op       = decode(alu_op, funct);

    alu_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .op_div (mdu_div),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done),
        .hi_nxt (mdu_hi),
        .lo_nxt (mdu_lo)
    );

    // Execute accepted ops, launch MUL/DIV, and retire them into HI/LO
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        mdu_start   = 1'b0;
        mdu_div     = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            case (op)
                OP_ADD:  result_d = src_a + src_b;
                OP_SUB:  result_d = src_a - src_b;
                OP_SLL:  result_d = src_b << shamt;
                OP_SRL:  result_d = src_b >> shamt;
                OP_AND:  result_d = src_a & src_b;
                OP_OR:   result_d = src_a | src_b;
                OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                OP_MFHI: result_d = hi_q;
                OP_MFLO: result_d = lo_q;
                OP_MULTU: begin
                    out_valid_d = 1'b0;
                    mdu_start   = 1'b1;
                    state_d     = MUL;
                end
                OP_DIVU: begin
                    out_valid_d = 1'b0;
                    mdu_start   = 1'b1;
                    mdu_div     = 1'b1;
                    state_d     = DIV;
                end
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end else if (mdu_done) begin
            state_d     = IDLE;
            hi_d        = mdu_hi;
            lo_d        = mdu_lo;
            result_d    = '0;
            out_valid_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: the issuer pushes expected responses
// from a plain-arithmetic reference model; a monitor pops on out_valid.
module tb_alu_ctrl_mdu;
    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     alu_op = 2'b00;
    logic [5:0]     funct = 6'd0;
    logic [SHW-1:0] shamt = '0;
    logic [W-1:0]   src_a = '0, src_b = '0;
    logic           out_valid, illegal;
    logic [W-1:0]   result, hi, lo;

    alu_ctrl_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .shamt(shamt), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .result(result), .illegal(illegal), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ill;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           checks = 0, failures = 0, cyc = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model straight from the op definitions
    function automatic void model(input logic [1:0] aop, input logic [5:0] fn,
                                  input logic [SHW-1:0] sh, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic ill, output bit md);
        logic [2*W-1:0] p;
        res = '0; ill = 1'b0; md = 1'b0;
        if (aop == 2'b00) res = a + b;
        else if (aop == 2'b01) res = a - b;
        else if (aop == 2'b11) ill = 1'b1;
        else begin
            case (fn)
                6'h21: res = a + b;
                6'h23: res = a - b;
                6'h00: res = b << sh;
                6'h02: res = b >> sh;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h10: res = m_hi;
                6'h12: res = m_lo;
                6'h19: begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; md = 1'b1;
                end
                6'h1B: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                    md = 1'b1;
                end
                default: ill = 1'b1;
            endcase
        end
    endfunction

    task automatic issue(input logic [1:0] aop, input logic [5:0] fn, input logic [SHW-1:0] sh,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit push = 1'b1);
        logic [W-1:0] r;
        logic         il;
        bit           md;
        int           waits;
        waits = 0;
        @(negedge clk);
        alu_op = aop; funct = fn; shamt = sh; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        model(aop, fn, sh, a, b, r, il, md);
        if (push) sbq.push_back('{r, m_hi, m_lo, il, cyc + 1 + (md ? W : 0)});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_result"}, result, '0);
        chk({tag, "_hi"}, hi, '0);
        chk({tag, "_lo"}, lo, '0);
        chk({tag, "_out_valid"}, W'(out_valid), '0);
        chk({tag, "_illegal"}, W'(illegal), '0);
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        m_hi = '0; m_lo = '0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every out_valid must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out_valid result=%h required=no_output", result);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", result, mon_e.res);
                    chk("illegal", W'(illegal), W'(mon_e.ill));
                    chk("hi", hi, mon_e.hi);
                    chk("lo", lo, mon_e.lo);
                    chk("latency_cycle", W'(cyc), W'(mon_e.cyc));
                end
            end else begin
                chk("illegal_without_valid", W'(illegal), '0);
            end
        end
    end

    localparam logic [5:0] FNL[11] = '{6'h21, 6'h23, 6'h00, 6'h02, 6'h24, 6'h25,
                                       6'h2A, 6'h19, 6'h1B, 6'h10, 6'h12};

    initial begin
        logic [1:0] aop;
        logic [5:0] fn;
        logic [W-1:0] a, b;
        int sel;

        reset_check("reset0");

        // simple ops, shifts, slt
        issue(2'b10, 6'h21, 0, 32'hFFFF_FFFF, 32'h1);
        issue(2'b10, 6'h23, 0, 32'd5, 32'd7);
        issue(2'b10, 6'h00, 5'd31, 32'h0, 32'h1);
        issue(2'b10, 6'h02, 5'd31, 32'h0, 32'h8000_0000);
        issue(2'b10, 6'h2A, 0, 32'hFFFF_FFFF, 32'h1);
        issue(2'b00, 6'h3F, 0, 32'd10, 32'd20);
        issue(2'b01, 6'h00, 0, 32'd3, 32'd9);
        drain();
        reset_check("reset_midrun");

        // multu with busy-window checks and a held request that must be ignored
        issue(2'b10, 6'h19, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_in_ready", W'(in_ready), '0);
            alu_op = 2'b00; src_a = 32'h55; src_b = 32'h1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_in_ready", W'(in_ready), W'(1));
        issue(2'b10, 6'h10, 0, 0, 0);
        drain();

        // divu, divide by zero, mflo right in the done cycle
        issue(2'b10, 6'h1B, 0, 32'd100, 32'd7);
        issue(2'b10, 6'h1B, 0, 32'h1234, 32'h0);
        issue(2'b10, 6'h12, 0, 0, 0);
        issue(2'b10, 6'h10, 0, 0, 0);

        // illegal ops leave HI/LO alone
        issue(2'b10, 6'h3F, 0, 32'h1, 32'h2);
        issue(2'b11, 6'h21, 0, 32'h1, 32'h2);
        drain();

        // random mix
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            aop = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : FNL[$urandom_range(0, 10)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            issue(aop, fn, 5'($urandom), a, b);
        end
        drain();

        // reset at iteration 10 of a multu: op abandoned, no out_valid
        issue(2'b10, 6'h19, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (9) @(posedge clk);
        reset_check("reset_in_mul");
        repeat (40) @(negedge clk);
        issue(2'b10, 6'h21, 0, 32'd40, 32'd2);
        issue(2'b10, 6'h10, 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes alu_op/funct into an operation, executes it, and returns a registered result over a valid/ready handshake. It adds an iterative multiply/divide unit with HI/LO registers, plus mfhi/mflo, so-called "multi-cycle" ops stall the issuing datapath through in_ready. It sits between the EX-stage control and the register-file writeback mux.

Parameters:
WIDTH, 32, datapath width in bits; must be at least 4 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request (high only in IDLE)
alu_op  in  2  00=add (ld/st), 01=sub (branch), 10=R-type decode by funct, 11=illegal
funct  in  6  R-type function field
shamt  in  SHW  shift amount for sll/srl
src_a  in  WIDTH  operand A (rs)
src_b  in  WIDTH  operand B (rt)
out_valid  out  1  one-cycle pulse: result/hi/lo are final
result  out  WIDTH  registered result
illegal  out  1  undecodable op; qualified by out_valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Accept on rising edge with in_valid & in_ready; inputs are sampled only at acceptance.
- Reset (async, rst_n=0): state=IDLE; result, hi, lo, counter, and partial registers all 0; out_valid=0, illegal=0; in_ready=1 after release. Reset mid-MUL/DIV abandons the op with no out_valid and HI/LO=0.
- Funct decode (alu_op=10): 100001 addu, 100011 subu, 000000 sll (src_b<<shamt), 000010 srl (logical), 100100 and, 100101 or, 101010 slt (signed, result 1 or 0), 011001 multu, 011011 divu, 010000 mfhi, 010010 mflo. Any other funct, or alu_op=11 -> illegal.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Single-cycle ops, illegal, mfhi, mflo: out_valid=1 in the cycle after the acceptance edge; in_ready stays 1. An illegal op gives result=0 and illegal=1; HI/LO are unchanged. This never drives an undriven or X value.
- result holds its last value while out_valid=0. illegal is 0 whenever out_valid=0.
- State machine: IDLE -> MUL on accepted multu; IDLE -> DIV on accepted divu; MUL/DIV -> IDLE when counter reaches WIDTH.
- MUL: unsigned shift-add, one bit per cycle. DIV: unsigned restoring division, one bit per cycle.
- MUL/DIV latency:
  - Acceptance edge E0.
  - Iterations on E1..E(WIDTH).
  - At E(WIDTH), HI/LO are written, out_valid=1 for the following cycle, and result=0.
  - in_ready=0 from after E0 until state returns to IDLE at E(WIDTH), so in_ready=1 in the out_valid cycle.
- multu: {hi,lo} = src_a*src_b (2*WIDTH bits). divu: lo=quotient, hi=remainder.
- divu by zero: lo = all ones, hi = src_a; full latency is still taken.
- mfhi/mflo issued in the out_valid cycle of multu/divu see the new HI/LO.
- in_valid while in_ready=0 is ignored; the requester must hold the request.

Decomposition:
- Shared package alu_pkg holds:
  - funct constants (FN_ADDU, FN_SUBU, FN_SLL, FN_SRL, FN_AND, FN_OR, FN_SLT, FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO);
  - alu_op encodings;
  - the op_e enum;
  - the state_e enum {IDLE, MUL, DIV}.
- One sub-module, alu_mdu_iter, contains the shared MUL/DIV datapath: a 2*WIDTH shift register and counter, with start/op/done ports. Decode and the single-cycle ALU stay in the top module.

Test Plan (WIDTH=32):
1. Reset and simple ops:
   - Reset asserted mid-run -> all outputs 0, in_ready=1.
   - addu 0xFFFFFFFF+1 -> result 0 one cycle later, out_valid pulse.
   - subu 5-7 -> 0xFFFFFFFE.
2. Shifts and slt:
   - sll 0x1 shamt=31 -> 0x80000000.
   - srl 0x80000000 shamt=31 -> 0x1.
   - slt src_a=0xFFFFFFFF, src_b=1 -> 1.
3. multu 0xFFFFFFFF*0xFFFFFFFF:
   - hi=0xFFFFFFFE, lo=0x00000001.
   - out_valid exactly 32 edges after acceptance.
   - in_ready=0 in between; in_valid asserted during busy is ignored.
4. divu:
   - 100/7 -> lo=14, hi=2.
   - 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
   - Back-to-back mflo in the done cycle -> result=0xFFFFFFFF.
5. Illegal ops:
   - funct=0x3F, or alu_op=11 -> out_valid=1, illegal=1, result=0, HI/LO unchanged.
   - rst_n pulsed low at iteration 10 of multu -> no out_valid, hi=lo=0, next addu correct.
